// File: rtl/mix_columns_seq_if.sv
// mix_columns_seq_if
//   Handshake bundle for the sequential MixColumns block.
//   master : the producer/consumer side (drives in_valid, in_state, out_ready)
//   slave  : the MixColumns block itself
//   Signals:
//     in_valid/in_ready/in_state    : input state handshake (128-bit state)
//     out_valid/out_ready/out_state : output state handshake (128-bit state)
//     busy                          : block is working on or holding a state
//     bypass                        : only when MIXCOL_BYPASS_EN is defined
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
`ifdef MIXCOL_BYPASS_EN
  logic         bypass;
`endif

  modport master (
`ifdef MIXCOL_BYPASS_EN
    output bypass,
`endif
    output in_valid,
    output in_state,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state,
    input  busy
  );

  modport slave (
`ifdef MIXCOL_BYPASS_EN
    input  bypass,
`endif
    input  in_valid,
    input  in_state,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state,
    output busy
  );
endinterface

// File: rtl/mix_columns_seq.sv
// mix_columns_seq
//   Forward AES MixColumns, one 32-bit column per clock. A state is accepted
//   in IDLE, its four columns are mixed over four BUSY cycles through one
//   shared column datapath, and the result is held in DONE until taken.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous reset, active-high
//     bus  : mix_columns_seq_if.slave (input/output handshakes, busy, bypass)
//   Parameters:
//     NCOL : columns per state, must be 4
//   Configuration macro:
//     MIXCOL_BYPASS_EN : adds bus.bypass; when latched high the columns are
//                        copied unchanged (AES final round)
//   Packing: column c = state[127-32c -: 32], row 0 byte is the column MSB.
module mix_columns_seq #(
  parameter int NCOL = 4
) (
  input  logic             clk,
  input  logic             rst,
  mix_columns_seq_if.slave bus
);

  if (NCOL != 4) begin : g_bad_ncol
    $error("mix_columns_seq: NCOL must be 4 for AES");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] in_buf_q, in_buf_d;
  logic [127:0] out_state_q, out_state_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
`ifdef MIXCOL_BYPASS_EN
  logic         bypass_q, bypass_d;
`endif

  logic [31:0]  col_in;
  logic [31:0]  col_mixed;
  logic [31:0]  col_out;

  // Multiply by x in GF(2^8), reducing by 0x11b.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the MixColumns matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    r3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    return {r0, r1, r2, r3};
  endfunction

  // Select the column being worked on and run it through the shared datapath.
  always_comb begin
    col_in = 32'h0;
    case (col_cnt_q)
      2'd0:    col_in = in_buf_q[127:96];
      2'd1:    col_in = in_buf_q[95:64];
      2'd2:    col_in = in_buf_q[63:32];
      default: col_in = in_buf_q[31:0];
    endcase
    col_mixed = mix_column(col_in);
`ifdef MIXCOL_BYPASS_EN
    col_out = bypass_q ? col_in : col_mixed;
`else
    col_out = col_mixed;
`endif
  end

  // Next-state logic. in_ready is IDLE-only, so an in_valid seen in IDLE is
  // a completed handshake; out_ready only matters in DONE.
  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    in_buf_d    = in_buf_q;
    out_state_d = out_state_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef MIXCOL_BYPASS_EN
    bypass_d    = bypass_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          in_buf_d  = bus.in_state;
`ifdef MIXCOL_BYPASS_EN
          bypass_d  = bus.bypass;
`endif
          col_cnt_d = 2'd0;
          busy_d    = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        case (col_cnt_q)
          2'd0:    out_state_d[127:96] = col_out;
          2'd1:    out_state_d[95:64]  = col_out;
          2'd2:    out_state_d[63:32]  = col_out;
          default: out_state_d[31:0]   = col_out;
        endcase
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      in_buf_q    <= 128'h0;
      out_state_q <= 128'h0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MIXCOL_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      in_buf_q    <= in_buf_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MIXCOL_BYPASS_EN
      bypass_q    <= bypass_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_state_q;
  assign bus.busy      = busy_q;

endmodule
